// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: merges LSU and ALU results onto the single register-file write port,
// buffers ALU results in a 2-entry FIFO and tracks outstanding destinations in a busy scoreboard.
module ysyx_22050612_wbu #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_alu_valid,
   output logic                         o_alu_ready,
   input  logic [ADDR_WIDTH-1:0]        i_alu_rd,
   input  logic [DATA_WIDTH-1:0]        i_alu_data,
   input  logic                         i_lsu_valid,
   output logic                         o_lsu_ready,
   input  logic [ADDR_WIDTH-1:0]        i_lsu_rd,
   input  logic [DATA_WIDTH-1:0]        i_lsu_data,
   input  logic                         i_issue_valid,
   input  logic [ADDR_WIDTH-1:0]        i_issue_rd,
   output logic                         o_wen,
   output logic [ADDR_WIDTH-1:0]        o_waddr,
   output logic [DATA_WIDTH-1:0]        o_wdata,
   output logic [(2**ADDR_WIDTH)-1:0]   o_busy,
   output logic                         o_idle
);

   localparam int unsigned NREG = 2**ADDR_WIDTH;

   logic [1:0]            r_count;
   logic                  r_rptr;
   logic                  r_wptr;
   logic [ADDR_WIDTH-1:0] r_rd   [2];
   logic [DATA_WIDTH-1:0] r_data [2];
   logic [NREG-1:0]       r_busy;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_lsu_wr;
   logic                  w_pop;
   logic                  w_push;
   logic [NREG-1:0]       w_busy_nxt;

   assign w_full  = (r_count == 2'd2);
   assign w_empty = (r_count == 2'd0);

   // Loads to x0 are dropped, leaving the port free for the FIFO head.
   assign w_lsu_wr = !i_rst && i_lsu_valid && (i_lsu_rd != '0);
   assign w_pop    = !i_rst && !w_lsu_wr && !w_empty;
   assign w_push   = i_alu_valid && !w_full && (i_alu_rd != '0);

   assign o_alu_ready = !w_full;
   assign o_lsu_ready = 1'b1;
   assign o_busy      = r_busy;
   assign o_idle      = w_empty && (r_busy == '0);

   always_comb begin
      o_wen   = 1'b0;
      o_waddr = '0;
      o_wdata = '0;
      if (w_lsu_wr) begin
         o_wen   = 1'b1;
         o_waddr = i_lsu_rd;
         o_wdata = i_lsu_data;
      end else if (w_pop) begin
         o_wen   = 1'b1;
         o_waddr = r_rd[r_rptr];
         o_wdata = r_data[r_rptr];
      end
   end

   // Clear before set so a same-cycle issue of the register being written keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (o_wen) begin
         w_busy_nxt[o_waddr] = 1'b0;
      end
      if (i_issue_valid && (i_issue_rd != '0)) begin
         w_busy_nxt[i_issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= 2'd0;
         r_rptr  <= 1'b0;
         r_wptr  <= 1'b0;
         r_busy  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         r_busy <= w_busy_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push) begin
         r_rd[r_wptr]   <= i_alu_rd;
         r_data[r_wptr] <= i_alu_data;
      end
   end

endmodule

// File: doc/ysyx_22050612_wbu.md
# ysyx_22050612_wbu

Writeback unit for the NPC core, directly upstream of the register file write port. Accepts completed results from the ALU path and the LSU path, and buffers ALU results in a 2-entry FIFO. Issues at most one register-file write per cycle, with LSU priority. Maintains a per-register busy scoreboard for decode-stage hazard checks.

## Interface
- `ADDR_WIDTH`, default 5: register index width; the register file holds 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, default 64: result and register width.

- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `alu_valid` input 1: ALU result present.
- `alu_ready` output 1: FIFO can accept; equals `!full`.
- `alu_rd` input ADDR_WIDTH: ALU destination register.
- `alu_data` input DATA_WIDTH: ALU result.
- `lsu_valid` input 1: load result present, valid for exactly one cycle.
- `lsu_ready` output 1: constant 1 out of reset; loads are never back-pressured.
- `lsu_rd` input ADDR_WIDTH: load destination.
- `lsu_data` input DATA_WIDTH: load data.
- `issue_valid` input 1: decode issued an instruction that writes `issue_rd`.
- `issue_rd` input ADDR_WIDTH: destination being issued.
- `wen` output 1: register-file write enable (combinational).
- `waddr` output ADDR_WIDTH: write address (combinational).
- `wdata` output DATA_WIDTH: write data (combinational).
- `busy` output 2**ADDR_WIDTH: bit i set means a write to register i is outstanding (registered).
- `idle` output 1: FIFO empty and `busy` all zero.

## Operation
- **ALU enqueue.** Occurs when `alu_valid && alu_ready`, at the posedge.
  - An entry with `alu_rd == 0` is accepted but not stored; the FIFO count is unchanged.
- **FIFO structure.**
  - 2 entries, circular, with 1-bit read/write pointers and a 2-bit count (0..2).
  - full = (count == 2); empty = (count == 0).
- **Write selection, each cycle, in priority order.**
  1. `lsu_valid && lsu_rd != 0`: `wen=1`, `waddr=lsu_rd`, `wdata=lsu_data`. The FIFO head is held.
  2. Otherwise, FIFO not empty: `wen=1` with the head's rd/data, and the head pops at the posedge.
  3. Otherwise: `wen=0`. `waddr` and `wdata` are don't-care, driven to 0.
  - An LSU result with rd 0 is discarded and frees the slot, so the FIFO head may write that cycle.
- **Simultaneous enqueue and pop.** Allowed; count is unchanged and pointers both advance.
  - `alu_ready` depends only on the current count; there is no same-cycle pass-through when full.
- **x0.** `wen` is never asserted with `waddr == 0`.
- **Scoreboard, at the posedge.**
  - Bit `issue_rd` is set when `issue_valid && issue_rd != 0`.
  - Bit `waddr` is cleared when `wen`.
  - Same register set and cleared in the same cycle: set wins.
  - Bit 0 is always 0.
- **Ordering.** Decode stalls on a busy destination (no WAW between ALU and LSU). The unit does not reorder writes to one register.

## Timing
- **Reset.**
  - count=0, pointers=0, `busy`=0.
  - `alu_ready=1`, `lsu_ready=1`, `wen=0`, `idle=1`.
  - FIFO data contents are unspecified.
- **Reset mid-operation.** Buffered entries are lost and all busy bits clear at that edge. No write is issued in the reset cycle: `wen` is forced 0 while `rst` is high.
- **LSU latency.** `wen` is asserted in the same cycle as `lsu_valid`; the register file is updated at the end of that cycle.
- **ALU latency.**
  - Accepted at edge N; written during cycle N+1 if no LSU write competes, else delayed one cycle per competing LSU write.
  - Throughput is 1 per cycle when no LSU writes occur.
- **Full FIFO with a competing LSU write.** Count stays 2 and `alu_ready` stays 0 until a pop.
- **`busy` and `idle`.** Reflect state after the edge; `busy` has one-cycle visibility latency to decode.

## Test plan
- **Reset.** Hold `rst` 2 cycles with random inputs → `wen=0`, `busy=0`, `alu_ready=1`, `idle=1`. Release, then ALU rd=5 data=0x11 → `wen=1`, `waddr=5`, `wdata=0x11` in the next cycle.
- **LSU priority.**
  - Drive: ALU rd=3 data=0xA accepted at edge 0; `lsu_valid` rd=7 data=0xB in cycles 1 and 2.
  - Required: writes to 7 in cycles 1–2; write 3/0xA in cycle 3.
- **Full and back-pressure.**
  - Drive: LSU writes every cycle for 4 cycles; ALU presents rd=1,2,3 back-to-back.
  - Required: rd=1,2 accepted; `alu_ready=0` afterwards. Once LSU stops, writes occur in order 1,2 then 3, with `alu_ready` returning to 1 the cycle after the first pop.
- **x0.**
  - ALU rd=0 data=0xFF → never written, count stays 0.
  - LSU rd=0 while the FIFO holds rd=4 → rd=4 written that cycle.
  - `wen && waddr==0` never occurs over a 10k-cycle random run.
- **Scoreboard.**
  - `issue_valid` rd=9 → `busy[9]=1` next cycle.
  - Write to 9 together with a same-cycle issue of 9 → `busy[9]` stays 1.
  - Next write to 9 with no issue → `busy[9]` cleared.
  - `idle=1` only when FIFO empty and `busy=0`.
- **Random vs. model.** 10k cycles of random ALU/LSU/issue traffic obeying the no-WAW rule; compare the write stream against a reference queue model. All ALU results must be written exactly once, in order, with none lost.
